// File: rtl/buffer_write_arbiter_pkg.sv
// Shared types and helpers for the buffer write arbiter: FSM state encoding
// and the winner-index width derived from the number of producers.
package buffer_write_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    GRANT     = 2'b01,
    WRITE     = 2'b10,
    WAIT_ROOM = 2'b11
  } arb_state_t;

  // Index width for NUM_REQ producers, i.e. $clog2(NUM_REQ), never below one bit.
  function automatic int idx_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/buffer_write_arbiter_rr_priority_picker.sv
// Combinational round-robin search: the first requester found scanning
// last+1, last+2, ... modulo NUM_REQ.
module rr_priority_picker
  import buffer_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               any,
  output logic [IDX_W-1:0]   win
);

  // Scan from the farthest candidate down to last+1 so the nearest one wins.
  always_comb begin
    int cand;
    win  = '0;
    cand = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = (int'(last) + k) % NUM_REQ;
      if (req[IDX_W'(cand)]) begin
        win = IDX_W'(cand);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/buffer_write_arbiter.sv
// Round-robin arbiter sharing the buffer's single write port between
// NUM_REQ producers; once a producer is granted its write always completes.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | no transaction; pick the next requester in round-robin order
// GRANT     | winner selected for one cycle; its word is captured on exit
// WAIT_ROOM | buffer full; hold grant until full is sampled low
// WRITE     | buff_w and ack pulse for one cycle; winner becomes 'last'
module buffer_write_arbiter
  import buffer_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
  input  logic                          full,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          buff_w,
  output logic [DATA_WIDTH-1:0]         buff_wdata,
  output logic                          busy
);

  localparam int IDX_W = idx_width(NUM_REQ);

  arb_state_t             state;
  logic [IDX_W-1:0]       win;
  logic [IDX_W-1:0]       last;
  logic [IDX_W-1:0]       pick;
  logic                   pick_any;
  logic [DATA_WIDTH-1:0]  win_word;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req  (req),
    .last (last),
    .any  (pick_any),
    .win  (pick)
  );

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (idx == IDX_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  always_comb begin
    win_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == IDX_W'(i)) win_word = wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // buff_wdata doubles as the capture register: loaded on leaving GRANT and
  // held through WAIT_ROOM, so a producer dropping req cannot disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      win        <= '0;
      last       <= IDX_W'(NUM_REQ - 1);
      grant      <= '0;
      ack        <= '0;
      buff_w     <= 1'b0;
      buff_wdata <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            win   <= pick;
            grant <= onehot(pick);
            busy  <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          buff_wdata <= win_word;
          if (!full) begin
            buff_w <= 1'b1;
            ack    <= onehot(win);
            state  <= WRITE;
          end else begin
            state <= WAIT_ROOM;
          end
        end
        WAIT_ROOM: begin
          if (!full) begin
            buff_w <= 1'b1;
            ack    <= onehot(win);
            state  <= WRITE;
          end
        end
        WRITE: begin
          last   <= win;
          grant  <= '0;
          ack    <= '0;
          buff_w <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_write_arbiter.sv
// Bench for buffer_write_arbiter: directed vector table followed by random
// producer traffic checked against a transaction-level reference model.
module tb_buffer_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] wdata;
  logic            full;
  logic [N-1:0]    grant;
  logic [N-1:0]    ack;
  logic            buff_w;
  logic [DW-1:0]   buff_wdata;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  buffer_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .wdata      (wdata),
    .full       (full),
    .grant      (grant),
    .ack        (ack),
    .buff_w     (buff_w),
    .buff_wdata (buff_wdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          rst;
    logic [N-1:0]  req;
    logic          full;
    logic [63:0]   wd;
    logic [N-1:0]  eg;
    logic [N-1:0]  ea;
    logic          ebw;
    logic          ebusy;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t vecs[$];

  localparam logic [63:0] WB = 64'h4444_3333_2222_1111;
  localparam logic [63:0] WX = 64'hDEAD_BEEF_CAFE_F00D;

  task automatic add(input logic r, input logic [N-1:0] rq, input logic f,
                     input logic [63:0] w, input logic [N-1:0] g,
                     input logic [N-1:0] a, input logic bw, input logic bs,
                     input logic [DW-1:0] d);
    vec_t v;
    v.rst = r; v.req = rq; v.full = f; v.wd = w;
    v.eg = g; v.ea = a; v.ebw = bw; v.ebusy = bs; v.ed = d;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual %h required %h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [N-1:0] eg, input logic [N-1:0] ea,
                          input logic ebw, input logic ebusy, input logic [DW-1:0] ed);
    chk({tag, "_grant"}, 64'(grant), 64'(eg));
    chk({tag, "_ack"},   64'(ack),   64'(ea));
    chk({tag, "_buffw"}, 64'(buff_w), 64'(ebw));
    chk({tag, "_busy"},  64'(busy),  64'(ebusy));
    if (ebw) chk({tag, "_data"}, 64'(buff_wdata), 64'(ed));
  endtask

  // Reference model state (transaction view)
  int            m_last;
  bit            m_active;
  bit            m_writing;
  bit            m_first;
  int            m_win;
  logic [DW-1:0] m_data;
  logic [DW-1:0] word [N];

  initial begin
    logic [N-1:0]  e_g, e_a;
    logic          e_bw, e_busy;
    logic [DW-1:0] e_d;
    bit            found;
    int            cand;

    rst = 1'b1; req = '0; full = 1'b0; wdata = WB;

    // reset state
    add(1, 4'b0000, 0, WB, 4'b0000, 4'b0000, 0, 0, 16'h0);
    // single requester 2, full=0
    add(0, 4'b0100, 0, WB, 4'b0100, 4'b0000, 0, 1, 16'h0);
    add(0, 4'b0100, 0, WB, 4'b0100, 4'b0100, 1, 1, 16'h3333);
    add(0, 4'b0000, 0, WB, 4'b0000, 4'b0000, 0, 0, 16'h0);
    // all four requesting, winners 0,1,2,3,0
    add(1, 4'b0000, 0, WB, 4'b0000, 4'b0000, 0, 0, 16'h0);
    add(0, 4'b1111, 0, WB, 4'b0001, 4'b0000, 0, 1, 16'h0);
    add(0, 4'b1111, 0, WB, 4'b0001, 4'b0001, 1, 1, 16'h1111);
    add(0, 4'b1111, 0, WB, 4'b0000, 4'b0000, 0, 0, 16'h0);
    add(0, 4'b1110, 0, WB, 4'b0010, 4'b0000, 0, 1, 16'h0);
    add(0, 4'b1111, 0, WB, 4'b0010, 4'b0010, 1, 1, 16'h2222);
    add(0, 4'b1111, 0, WB, 4'b0000, 4'b0000, 0, 0, 16'h0);
    add(0, 4'b1101, 0, WB, 4'b0100, 4'b0000, 0, 1, 16'h0);
    add(0, 4'b1111, 0, WB, 4'b0100, 4'b0100, 1, 1, 16'h3333);
    add(0, 4'b1111, 0, WB, 4'b0000, 4'b0000, 0, 0, 16'h0);
    add(0, 4'b1011, 0, WB, 4'b1000, 4'b0000, 0, 1, 16'h0);
    add(0, 4'b1111, 0, WB, 4'b1000, 4'b1000, 1, 1, 16'h4444);
    add(0, 4'b1111, 0, WB, 4'b0000, 4'b0000, 0, 0, 16'h0);
    add(0, 4'b0111, 0, WB, 4'b0001, 4'b0000, 0, 1, 16'h0);
    add(0, 4'b1111, 0, WB, 4'b0001, 4'b0001, 1, 1, 16'h1111);
    add(0, 4'b0000, 0, WB, 4'b0000, 4'b0000, 0, 0, 16'h0);
    // requests 1 and 3 after last=3; 1 holding req after ack loses to 3
    add(1, 4'b0000, 0, WB, 4'b0000, 4'b0000, 0, 0, 16'h0);
    add(0, 4'b1010, 0, WB, 4'b0010, 4'b0000, 0, 1, 16'h0);
    add(0, 4'b1010, 0, WB, 4'b0010, 4'b0010, 1, 1, 16'h2222);
    add(0, 4'b1010, 0, WB, 4'b0000, 4'b0000, 0, 0, 16'h0);
    add(0, 4'b1010, 0, WB, 4'b1000, 4'b0000, 0, 1, 16'h0);
    add(0, 4'b1010, 0, WB, 4'b1000, 4'b1000, 1, 1, 16'h4444);
    add(0, 4'b0010, 0, WB, 4'b0000, 4'b0000, 0, 0, 16'h0);
    add(0, 4'b0010, 0, WB, 4'b0010, 4'b0000, 0, 1, 16'h0);
    add(0, 4'b0010, 0, WB, 4'b0010, 4'b0010, 1, 1, 16'h2222);
    add(0, 4'b0000, 0, WB, 4'b0000, 4'b0000, 0, 0, 16'h0);
    // full=1 for 5 samples from GRANT; data altered after capture; full ignored in IDLE
    add(0, 4'b0001, 1, WB, 4'b0001, 4'b0000, 0, 1, 16'h0);
    add(0, 4'b0001, 1, WB, 4'b0001, 4'b0000, 0, 1, 16'h0);
    for (int i = 0; i < 4; i++)
      add(0, 4'b0001, 1, WX, 4'b0001, 4'b0000, 0, 1, 16'h0);
    add(0, 4'b0001, 0, WX, 4'b0001, 4'b0001, 1, 1, 16'h1111);
    add(0, 4'b0000, 0, WB, 4'b0000, 4'b0000, 0, 0, 16'h0);
    // req[1] drops during WAIT_ROOM
    add(0, 4'b0010, 0, WB, 4'b0010, 4'b0000, 0, 1, 16'h0);
    add(0, 4'b0010, 1, WB, 4'b0010, 4'b0000, 0, 1, 16'h0);
    add(0, 4'b0000, 1, WX, 4'b0010, 4'b0000, 0, 1, 16'h0);
    add(0, 4'b0000, 0, WX, 4'b0010, 4'b0010, 1, 1, 16'h2222);
    add(0, 4'b0000, 0, WB, 4'b0000, 4'b0000, 0, 0, 16'h0);
    // rst in WAIT_ROOM aborts; producer 0 has priority afterwards
    add(0, 4'b0100, 1, WB, 4'b0100, 4'b0000, 0, 1, 16'h0);
    add(0, 4'b0100, 1, WB, 4'b0100, 4'b0000, 0, 1, 16'h0);
    add(1, 4'b0100, 0, WB, 4'b0000, 4'b0000, 0, 0, 16'h0);
    add(0, 4'b1001, 0, WB, 4'b0001, 4'b0000, 0, 1, 16'h0);
    add(0, 4'b1001, 0, WB, 4'b0001, 4'b0001, 1, 1, 16'h1111);
    add(0, 4'b0000, 0, WB, 4'b0000, 4'b0000, 0, 0, 16'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; req = vecs[i].req; full = vecs[i].full; wdata = vecs[i].wd;
      @(posedge clk); #1;
      chk_outs($sformatf("tbl%0d", i), vecs[i].eg, vecs[i].ea, vecs[i].ebw,
               vecs[i].ebusy, vecs[i].ed);
    end

    // Random producers against the reference model
    m_last = N - 1; m_active = 0; m_writing = 0; m_first = 0; m_win = 0; m_data = '0;
    req = '0;
    for (int i = 0; i < N; i++) word[i] = DW'($urandom);
    for (int c = 0; c < 4000; c++) begin
      rst  = (c == 0) || ($urandom_range(0, 299) == 0);
      full = ($urandom_range(0, 9) < 4);
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          word[i] = DW'($urandom);
          if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
        end else if ($urandom_range(0, 15) == 0) begin
          req[i] = 1'b0;
        end
      end
      wdata = {word[3], word[2], word[1], word[0]};

      e_g = '0; e_a = '0; e_bw = 1'b0; e_busy = 1'b0; e_d = '0;
      if (rst) begin
        m_last = N - 1; m_active = 0; m_writing = 0;
      end else if (!m_active) begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          cand = (m_last + k) % N;
          if (!found && req[cand[1:0]]) begin
            found = 1; m_win = cand;
          end
        end
        if (found) begin
          m_active = 1; m_first = 1;
          e_g = N'(1) << m_win; e_busy = 1'b1;
        end
      end else if (m_writing) begin
        m_last = m_win; m_active = 0; m_writing = 0;
      end else begin
        if (m_first) begin
          m_data  = word[m_win];
          m_first = 0;
        end
        e_g = N'(1) << m_win; e_busy = 1'b1;
        if (!full) begin
          m_writing = 1;
          e_a = e_g; e_bw = 1'b1; e_d = m_data;
        end
      end

      @(posedge clk); #1;
      chk_outs("rnd", e_g, e_a, e_bw, e_busy, e_d);
      for (int i = 0; i < N; i++) if (e_a[i]) req[i] = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
